// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master: it issues addr/req and receives valid/rdata.
interface fetch_pc_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction from
// imem, holds it for decode/execute and redirects on commit (no delay slot).
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  fetch_pc_unit_if.master    imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [5:0]         op,
  output logic [5:0]         funct,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        link_addr,
  input  logic               commit,
  input  logic               jump,
  input  logic               jumpReg,
  input  logic               branchatall,
  input  logic               bne,
  input  logic               zero,
  input  logic [31:0]        reg_target,
  output logic               align_err,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(IMEM_TIMEOUT);

  state_t          state_reg;
  logic [31:0]     pc_reg;
  logic [31:0]     instr_reg;
  logic            instr_valid_reg;
  logic            align_err_reg;
  logic            fetch_err_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic [CW-1:0]   wait_cnt_next;

  logic [31:0]     pc_plus4_w;
  logic [31:0]     branch_off;
  logic            branch_taken;
  logic [31:0]     pc_next;

  assign pc_plus4_w    = pc_reg + 32'd4;
  assign branch_off    = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign branch_taken  = branchatall & (zero ^ bne);
  assign wait_cnt_next = wait_cnt_reg + 1'b1;

  // Redirect priority: JR, then J/JAL, then taken branch, else sequential.
  always_comb begin
    pc_next = pc_plus4_w;
    if (jumpReg)
      pc_next = {reg_target[31:2], 2'b00};
    else if (jump)
      pc_next = {pc_plus4_w[31:28], instr_reg[25:0], 2'b00};
    else if (branch_taken)
      pc_next = pc_plus4_w + branch_off;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'd0;
      instr_valid_reg <= 1'b0;
      align_err_reg   <= 1'b0;
      fetch_err_reg   <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (imem.imem_valid) begin
            instr_reg       <= imem.imem_rdata;
            instr_valid_reg <= 1'b1;
            state_reg       <= S_HOLD;
          end else begin
            wait_cnt_reg    <= '0;
            state_reg       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_valid) begin
            instr_reg       <= imem.imem_rdata;
            instr_valid_reg <= 1'b1;
            wait_cnt_reg    <= '0;
            state_reg       <= S_HOLD;
          end else if (wait_cnt_reg != TIMEOUT_CNT) begin
            // Counter saturates at the timeout; the error flag is sticky.
            wait_cnt_reg <= wait_cnt_next;
            if (wait_cnt_next == TIMEOUT_CNT)
              fetch_err_reg <= 1'b1;
          end
        end
        S_HOLD: begin
          if (commit) begin
            pc_reg          <= pc_next;
            instr_valid_reg <= 1'b0;
            state_reg       <= S_FETCH;
            if (jumpReg && (reg_target[1:0] != 2'b00))
              align_err_reg <= 1'b1;
          end
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // The request is a decode of the FETCH state, masked while reset is held.
  assign imem.imem_req  = (state_reg == S_FETCH) && !reset;
  assign imem.imem_addr = pc_reg;

  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign op          = instr_reg[31:26];
  assign funct       = instr_reg[5:0];
  assign pc          = pc_reg;
  assign pc_plus4    = pc_plus4_w;
  assign link_addr   = pc_plus4_w;
  assign align_err   = align_err_reg;
  assign fetch_err   = fetch_err_reg;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the program counter and requests instructions from instruction memory with a valid handshake.
- Holds the fetched word stable for decode/execute and presents op/funct to the decoder.
- Computes the next PC from the decoder's jump/branch controls when the current instruction commits. No branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_TIMEOUT, 16, cycles in S_WAIT without imem_valid before fetch_err sets.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- imem_addr  output  32  fetch address, equals pc
- imem_req  output  1  fetch request, one-cycle pulse
- imem_valid  input  1  imem_rdata valid this cycle
- imem_rdata  input  32  instruction word from memory
- instr  output  32  latched instruction
- instr_valid  output  1  instr valid for decode/execute
- op  output  6  instr[31:26] to decoder Op
- funct  output  6  instr[5:0] to decoder funct
- pc  output  32  address of the current instruction
- pc_plus4  output  32  pc + 4
- link_addr  output  32  return address for JAL, equals pc_plus4
- commit  input  1  current instruction finished; apply redirect
- jump  input  1  from decoder
- jumpReg  input  1  from decoder
- branchatall  input  1  from decoder
- bne  input  1  from decoder
- zero  input  1  ALU zero flag (rs − rt == 0)
- reg_target  input  32  rs value for JR
- align_err  output  1  sticky flag: JR target had nonzero bits [1:0]
- fetch_err  output  1  sticky flag: imem timeout

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, align_err=0, fetch_err=0, state=S_FETCH, timeout counter=0.
- Reset has priority over every other input in any state. Instruction memory shares the same reset, so no stale responses arrive after reset.

States:
- S_FETCH:
  - Drive imem_req=1 and imem_addr=pc for exactly one cycle.
  - If imem_valid is asserted in the same cycle (zero-wait memory): latch instr←imem_rdata and go to S_HOLD.
  - Otherwise go to S_WAIT.
- S_WAIT:
  - imem_req=0; the counter increments each cycle.
  - On imem_valid: latch instr, clear the counter, go to S_HOLD.
  - When the counter reaches IMEM_TIMEOUT: set fetch_err and stay in S_WAIT; the counter saturates.
- S_HOLD:
  - instr_valid=1; instr and pc are stable.
  - On commit: update pc←next_pc, set instr_valid←0, go to S_FETCH.
  - Without commit: hold indefinitely (stall).

Other rules:
- commit, jump, jumpReg, branchatall, bne, zero and reg_target are sampled only in S_HOLD with commit=1. They are ignored elsewhere.
- imem_valid outside S_FETCH/S_WAIT is ignored.
- next_pc priority: jumpReg > jump > taken branch > pc_plus4.
  - JR: {reg_target[31:2],2'b00}. If reg_target[1:0]≠0, set align_err; the PC still updates to the forced-aligned value.
  - J/JAL: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Branch: taken = branchatall & (zero ^ bne); target = pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
- Arithmetic is 32-bit modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- Latency:
  - Zero-wait memory: 1 cycle fetch to instr_valid; minimum 2 cycles per instruction (FETCH, HOLD+commit).
  - N-wait memory: 1+N cycles.
- op, funct and link_addr are combinational from the registered instr/pc.

Test Plan:
- Reset, zero-wait memory: imem_addr=0 with imem_req for 1 cycle; next cycle instr_valid=1, instr=imem_rdata; commit with no controls → pc=4, imem_req next cycle.
- 3-cycle memory latency: imem_valid asserted 3 cycles after req → instr_valid rises the following cycle; no duplicate req; holding commit=0 for 5 cycles keeps pc/instr unchanged.
- BEQ at pc=0x40, imm=16'hFFFE, zero=1 → pc=0x3C. Same with zero=0 → 0x44. BNE with zero=0 → 0x3C.
- J at pc=0x1000_0010, target field=26'h000_0040 → pc=0x1000_0100. JAL gives link_addr=0x1000_0014 during HOLD.
- JR with reg_target=0x0000_0203 → pc=0x200, align_err=1 until reset. jumpReg+jump both set → JR wins.
- Edge cases:
  - Reset asserted in S_WAIT → pc=RESET_PC, instr_valid=0, flags cleared, fresh req next cycle.
  - No imem_valid for 16 cycles → fetch_err=1.
  - pc=0xFFFF_FFFC commit → pc=0.
